// File: rtl/bank_write_sched.sv
// Round-robin write scheduler for a 5-bit register bank with idle clock gating.
// One grant per cycle; after IDLE_CYCLES quiet cycles the bank is parked until a request wakes it.
module bank_write_sched #(
  parameter int unsigned IDLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] REQ,
  input  logic [4:0] REQ_D,
  output logic [4:0] ACK,
  output logic [4:0] EN,
  output logic       D_OUT,
  output logic       IDLE
);

  localparam int unsigned N_REQ = 5;
  localparam int unsigned PTR_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {RUN, GATED, WAKE} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt, idle_cnt_inc;
  logic [N_REQ-1:0] eligible, grant_nxt;
  logic             d_nxt, idle_nxt;
  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // A requester still showing its ACK is not re-granted.
  assign eligible = REQ & ~ACK;

  assign idle_cnt_inc = (idle_cnt >= CNT_W'(IDLE_CYCLES)) ? idle_cnt : idle_cnt + 1'b1;

  // Round-robin search starting at ptr, wrapping 4 -> 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      idx = (sum >= (PTR_W+1)'(N_REQ)) ? PTR_W'(sum - (PTR_W+1)'(N_REQ)) : PTR_W'(sum);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    idle_cnt_nxt = idle_cnt;
    grant_nxt    = '0;
    d_nxt        = D_OUT;
    idle_nxt     = 1'b0;
    unique case (state)
      RUN: begin
        if (found) begin
          grant_nxt    = N_REQ'(1) << win;
          d_nxt        = REQ_D[win];
          ptr_nxt      = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
          idle_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_cnt_inc;
          if (idle_cnt_inc == CNT_W'(IDLE_CYCLES)) begin
            state_nxt = GATED;
            idle_nxt  = 1'b1;
          end
        end
      end
      GATED: begin
        idle_nxt = 1'b1;
        if (|REQ) begin
          state_nxt = WAKE;
          idle_nxt  = 1'b0;
        end
      end
      WAKE: begin
        // Single settle cycle while the bank clock restarts.
        state_nxt    = RUN;
        idle_cnt_nxt = '0;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      ptr      <= '0;
      idle_cnt <= '0;
      ACK      <= '0;
      EN       <= '0;
      D_OUT    <= 1'b0;
      IDLE     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      idle_cnt <= idle_cnt_nxt;
      ACK      <= grant_nxt;
      EN       <= grant_nxt;
      D_OUT    <= d_nxt;
      IDLE     <= idle_nxt;
    end
  end

endmodule

// File: tb/tb_bank_write_sched.sv
// Scoreboard bench for bank_write_sched: directed scenarios plus randomized requesters,
// with expectations from a cycle-level reference model of the arbitration rules.
module tb_bank_write_sched;

  localparam int unsigned IDLE_CYC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req, req_d;
  logic [4:0] ack, en;
  logic       d_out, idle;

  bank_write_sched #(.IDLE_CYCLES(IDLE_CYC)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .REQ_D(req_d),
    .ACK(ack), .EN(en), .D_OUT(d_out), .IDLE(idle)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct { int cyc; int idx; logic d; } grant_t;
  typedef struct { logic [4:0] en; logic d; logic idle; } snap_t;
  grant_t grant_q[$];
  snap_t  snap_q[$];

  typedef enum {M_RUN, M_GATED, M_WAKE} mode_t;
  mode_t m_mode  = M_RUN;
  int    m_ptr   = 0;
  int    m_quiet = 0;
  int    m_grant = -1;
  logic  m_d     = 1'b0;
  logic  m_idle  = 1'b0;
  logic [4:0] linger = '0;

  // Reference: what the bank sees after the next edge, given this cycle's inputs.
  task automatic model_step(input logic r, input logic [4:0] rq, input logic [4:0] rd);
    int w;
    w = -1;
    if (r) begin
      m_mode = M_RUN; m_ptr = 0; m_quiet = 0; m_grant = -1; m_d = 1'b0; m_idle = 1'b0;
      return;
    end
    case (m_mode)
      M_RUN: begin
        for (int k = 0; k < 5; k++) begin
          int i;
          i = (m_ptr + k) % 5;
          if (w < 0 && rq[3'(i)] && m_grant != i) w = i;
        end
        if (w >= 0) begin
          m_grant = w; m_d = rd[3'(w)]; m_ptr = (w + 1) % 5; m_quiet = 0;
        end else begin
          m_grant = -1;
          m_quiet++;
          if (m_quiet >= int'(IDLE_CYC)) begin m_mode = M_GATED; m_idle = 1'b1; end
        end
      end
      M_GATED: begin
        m_grant = -1;
        if (rq != 5'd0) begin m_mode = M_WAKE; m_idle = 1'b0; end
      end
      default: begin
        m_grant = -1; m_mode = M_RUN; m_quiet = 0;
      end
    endcase
  endtask

  task automatic tick();
    snap_t  s;
    grant_t g;
    model_step(rst, req, req_d);
    @(posedge clk);
    cyc++;
    s.en   = (m_grant >= 0) ? (5'(1) << m_grant) : 5'd0;
    s.d    = m_d;
    s.idle = m_idle;
    snap_q.push_back(s);
    if (m_grant >= 0) begin
      g.cyc = cyc; g.idx = m_grant; g.d = m_d;
      grant_q.push_back(g);
    end
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 'h%0h, expected 'h%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations as the DUT presents each cycle's outputs.
  snap_t  ms;
  grant_t mg;
  always @(negedge clk) begin
    if (snap_q.size() > 0) begin
      ms = snap_q.pop_front();
      n_tests++;
      if (en !== ms.en || ack !== ms.en || d_out !== ms.d || idle !== ms.idle) begin
        n_fail++;
        $display("FAIL cycle_outputs (cycle %0d): got en=%b ack=%b d=%b idle=%b, expected en=%b ack=%b d=%b idle=%b",
                 cyc, en, ack, d_out, idle, ms.en, ms.en, ms.d, ms.idle);
      end
      n_tests++;
      if (en !== ack || $countones(en) > 1 || (idle && en != 5'd0)) begin
        n_fail++;
        $display("FAIL invariant (cycle %0d): got en=%b ack=%b idle=%b, expected en==ack, onehot0, no en while idle",
                 cyc, en, ack, idle);
      end
      if (en != 5'd0) begin
        n_tests++;
        if (grant_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_grant (cycle %0d): got en=%b, expected no grant", cyc, en);
        end else begin
          mg = grant_q.pop_front();
          if (mg.cyc != cyc || en !== (5'(1) << mg.idx) || d_out !== mg.d) begin
            n_fail++;
            $display("FAIL grant (cycle %0d): got en=%b d=%b, expected cycle %0d en=%b d=%b",
                     cyc, en, d_out, mg.cyc, 5'(1) << mg.idx, mg.d);
          end
        end
      end
    end
  end

  task automatic rand_cycle(input bit busy);
    logic [4:0] nreq, nd;
    nreq = req;
    nd   = req_d;
    rst  = ($urandom_range(0, 199) == 0);
    for (int i = 0; i < 5; i++) begin
      if (linger[3'(i)]) begin
        nreq[3'(i)] = 1'b0; linger[3'(i)] = 1'b0;
      end else if (req[3'(i)] && m_grant == i) begin
        if ($urandom_range(0, 3) == 0) linger[3'(i)] = 1'b1;
        else nreq[3'(i)] = 1'b0;
      end else if (req[3'(i)]) begin
        if ($urandom_range(0, 29) == 0) nreq[3'(i)] = 1'b0;
      end else if ($urandom_range(0, busy ? 2 : 39) == 0) begin
        nreq[3'(i)] = 1'b1;
        nd[3'(i)]   = 1'($urandom_range(0, 1));
      end
    end
    req   = nreq;
    req_d = nd;
    tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; req_d = '0;
    tick(); tick();
    chk("reset_en", int'(en), 0);
    chk("reset_ack", int'(ack), 0);
    chk("reset_dout", int'(d_out), 0);
    chk("reset_idle", int'(idle), 0);

    // Single requester, one-cycle latency, data held after grant.
    rst = 1'b0; req = 5'b00100; req_d = 5'b00100;
    tick();
    chk("single_en", int'(en), 'b00100);
    chk("single_ack", int'(ack), 'b00100);
    chk("single_dout", int'(d_out), 1);
    req = '0;
    tick();
    chk("single_en_off", int'(en), 0);
    chk("single_dout_hold", int'(d_out), 1);

    // All requesters: grants 0..4 back to back.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 5'b11111; req_d = 5'b10101;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_en", int'(en), 1 << k);
      chk("rr_dout", int'(d_out), (k % 2 == 0) ? 1 : 0);
      req[3'(k)] = 1'b0;
    end

    // Wrap-around from pointer 3.
    req = 5'b00100; req_d = '0;
    tick(); chk("wrap_pre_en", int'(en), 'b00100);
    req = 5'b00011;
    tick(); chk("wrap_first_en", int'(en), 'b00001);
    req = 5'b00010;
    tick(); chk("wrap_second_en", int'(en), 'b00010);
    req = '0;
    tick(); chk("wrap_done_en", int'(en), 0);

    // Idle gating and wake latency.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (3) tick();
    chk("gate_c4_idle", int'(idle), 0);
    tick();
    chk("gate_c5_idle", int'(idle), 1);
    repeat (5) tick();
    chk("gate_c10_idle", int'(idle), 1);
    req = 5'b01000; req_d = 5'b01000;
    tick();
    chk("wake_c11_idle", int'(idle), 0);
    chk("wake_c11_en", int'(en), 0);
    tick();
    chk("wake_c12_en", int'(en), 0);
    tick();
    chk("wake_c13_en", int'(en), 'b01000);
    chk("wake_c13_dout", int'(d_out), 1);
    req = '0;
    tick();

    // Reset drops a pending grant and restarts the pointer.
    req = 5'b00100; tick();
    req = '0; tick();
    rst = 1'b1; req = 5'b00010; tick();
    chk("rst_grant_en", int'(en), 0);
    chk("rst_grant_ack", int'(ack), 0);
    chk("rst_grant_dout", int'(d_out), 0);
    chk("rst_grant_idle", int'(idle), 0);
    rst = 1'b0; req = 5'b01010;
    tick(); chk("post_rst_en", int'(en), 'b00010);
    req = 5'b01000;
    tick(); chk("post_rst_en2", int'(en), 'b01000);
    req = '0;
    tick();

    // Randomized requesters alternating busy and sparse phases.
    for (int n = 0; n < 3000; n++) rand_cycle(((n / 250) % 2) == 0);

    rst = 1'b0; req = '0;
    repeat (2) tick();
    @(negedge clk); #1;
    chk("grant_queue_drained", grant_q.size(), 0);
    chk("snap_queue_drained", snap_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
